// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing and test-pattern generator:
// pattern codes, the colour-bar table and a 640x480@60 default timing set.
package vga_pkg;

    localparam logic [2:0] PAT_BLACK   = 3'd0;
    localparam logic [2:0] PAT_RED     = 3'd1;
    localparam logic [2:0] PAT_GREEN   = 3'd2;
    localparam logic [2:0] PAT_BLUE    = 3'd3;
    localparam logic [2:0] PAT_CHECKER = 3'd4;
    localparam logic [2:0] PAT_BARS    = 3'd5;
    localparam logic [2:0] PAT_BORDER  = 3'd6;
    localparam logic [2:0] PAT_RAMP    = 3'd7;

    localparam int NUM_BARS = 8;

    // Each entry is {R,G,B} on/off; index 0 is the leftmost bar (white).
    localparam logic [NUM_BARS-1:0][2:0] BAR_RGB = {
        3'b000,   // black
        3'b001,   // blue
        3'b100,   // red
        3'b101,   // magenta
        3'b010,   // green
        3'b011,   // cyan
        3'b110,   // yellow
        3'b111    // white
    };

    localparam int DEF_ACTIVE_COLS = 640;
    localparam int DEF_H_FRONT     = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BACK      = 48;
    localparam int DEF_ACTIVE_ROWS = 480;
    localparam int DEF_V_FRONT     = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BACK      = 33;

    // Counter width that stays at least one bit even for a range of 1.
    function automatic int min1_clog2(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Column/row raster counter with decoded active, sync and line/frame strobes.
// All decodes are combinational from the current counter state.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BACK      = DEF_V_BACK,
    localparam int TOTAL_COLS = ACTIVE_COLS + H_FRONT + H_SYNC + H_BACK,
    localparam int TOTAL_ROWS = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK,
    localparam int CW         = $clog2(TOTAL_COLS),
    localparam int RW         = $clog2(TOTAL_ROWS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic [CW-1:0] o_col,
    output logic [RW-1:0] o_row,
    output logic          o_de,
    output logic          o_hsync_on,
    output logic          o_vsync_on,
    output logic          o_line_start,
    output logic          o_frame_start,
    output logic          o_line_end,
    output logic          o_frame_end
);

    localparam int HS_START = ACTIVE_COLS + H_FRONT;
    localparam int HS_STOP  = HS_START + H_SYNC;
    localparam int VS_START = ACTIVE_ROWS + V_FRONT;
    localparam int VS_STOP  = VS_START + V_SYNC;

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          last_col;
    logic          last_row;

    assign last_col = (col_q == CW'(TOTAL_COLS - 1));
    assign last_row = (row_q == RW'(TOTAL_ROWS - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (last_col) begin
            col_q <= '0;
            row_q <= last_row ? '0 : row_q + RW'(1);
        end else begin
            col_q <= col_q + CW'(1);
        end
    end

    // Sync windows are half-open: [START, STOP).
    assign o_col         = col_q;
    assign o_row         = row_q;
    assign o_de          = (col_q < CW'(ACTIVE_COLS)) && (row_q < RW'(ACTIVE_ROWS));
    assign o_hsync_on    = (col_q >= CW'(HS_START)) && (col_q < CW'(HS_STOP));
    assign o_vsync_on    = (row_q >= RW'(VS_START)) && (row_q < RW'(VS_STOP));
    assign o_line_start  = (col_q == '0);
    assign o_frame_start = (col_q == '0) && (row_q == '0);
    assign o_line_end    = last_col;
    assign o_frame_end   = last_col && last_row;

endmodule

// File: rtl/vga_timing_pattern_gen.sv
// Parametrised VGA timing generator with an 8-mode test pattern source.
// Pattern changes are synchronised and only take effect at frame boundaries.
module vga_timing_pattern_gen
    import vga_pkg::*;
#(
    parameter int VIDEO_WIDTH = 3,
    parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BACK      = DEF_V_BACK,
    parameter bit HSYNC_POL   = 1'b0,
    parameter bit VSYNC_POL   = 1'b0,
    parameter int CHECK_LOG2  = 5,
    localparam int TOTAL_COLS = ACTIVE_COLS + H_FRONT + H_SYNC + H_BACK,
    localparam int TOTAL_ROWS = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK,
    localparam int CW         = $clog2(TOTAL_COLS),
    localparam int RW         = $clog2(TOTAL_ROWS)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [2:0]             i_pattern,
    input  logic                   i_blank,
    output logic                   o_hsync,
    output logic                   o_vsync,
    output logic                   o_de,
    output logic                   o_frame_start,
    output logic                   o_line_start,
    output logic [CW-1:0]          o_col,
    output logic [RW-1:0]          o_row,
    output logic [VIDEO_WIDTH-1:0] o_red,
    output logic [VIDEO_WIDTH-1:0] o_green,
    output logic [VIDEO_WIDTH-1:0] o_blue
);

    localparam int BAR_W      = ACTIVE_COLS / NUM_BARS;
    localparam int BAR_CW     = min1_clog2(BAR_W);
    localparam int RAMP_SHIFT = $clog2(ACTIVE_COLS) - VIDEO_WIDTH;
    localparam logic [VIDEO_WIDTH-1:0] FULL = {VIDEO_WIDTH{1'b1}};

    if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_porch
        $error("vga_timing_pattern_gen: porch and sync widths must be non-zero");
    end
    if (ACTIVE_COLS < 8 || (ACTIVE_COLS % 8) != 0 || ACTIVE_ROWS < 1) begin : g_bad_active
        $error("vga_timing_pattern_gen: ACTIVE_COLS must be a non-zero multiple of 8");
    end
    if (VIDEO_WIDTH < 1 || RAMP_SHIFT < 0) begin : g_bad_width
        $error("vga_timing_pattern_gen: VIDEO_WIDTH must be 1..clog2(ACTIVE_COLS)");
    end
    if (CHECK_LOG2 < 0 || CHECK_LOG2 >= CW || CHECK_LOG2 >= RW) begin : g_bad_check
        $error("vga_timing_pattern_gen: CHECK_LOG2 exceeds counter width");
    end

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          de;
    logic          hsync_on;
    logic          vsync_on;
    logic          line_start;
    logic          frame_start;
    logic          line_end;
    logic          frame_end;

    vga_timing_counter #(
        .ACTIVE_COLS (ACTIVE_COLS),
        .H_FRONT     (H_FRONT),
        .H_SYNC      (H_SYNC),
        .H_BACK      (H_BACK),
        .ACTIVE_ROWS (ACTIVE_ROWS),
        .V_FRONT     (V_FRONT),
        .V_SYNC      (V_SYNC),
        .V_BACK      (V_BACK)
    ) u_counter (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_col         (col),
        .o_row         (row),
        .o_de          (de),
        .o_hsync_on    (hsync_on),
        .o_vsync_on    (vsync_on),
        .o_line_start  (line_start),
        .o_frame_start (frame_start),
        .o_line_end    (line_end),
        .o_frame_end   (frame_end)
    );

    logic [2:0] pat_meta;
    logic [2:0] pat_sync;
    logic [2:0] pat_q;

    // i_pattern may be asynchronous; pat_q only changes on the last pixel of a frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pat_meta <= PAT_BLACK;
            pat_sync <= PAT_BLACK;
            pat_q    <= PAT_BLACK;
        end else begin
            pat_meta <= i_pattern;
            pat_sync <= pat_meta;
            if (frame_end) begin
                pat_q <= pat_sync;
            end
        end
    end

    logic [BAR_CW-1:0] bar_cnt_q;
    logic [2:0]        bar_idx_q;

    // Bar index tracks the column incrementally so no divider is needed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
        end else if (line_end) begin
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
        end else if (bar_cnt_q == BAR_CW'(BAR_W - 1)) begin
            bar_cnt_q <= '0;
            bar_idx_q <= bar_idx_q + 3'd1;
        end else begin
            bar_cnt_q <= bar_cnt_q + BAR_CW'(1);
        end
    end

    logic [2:0]             bar_rgb;
    logic [CW-1:0]          ramp_full;
    logic                   on_border;
    logic [VIDEO_WIDTH-1:0] red_d;
    logic [VIDEO_WIDTH-1:0] green_d;
    logic [VIDEO_WIDTH-1:0] blue_d;

    assign bar_rgb   = BAR_RGB[bar_idx_q];
    assign ramp_full = col >> RAMP_SHIFT;
    assign on_border = (col == '0) || (col == CW'(ACTIVE_COLS - 1)) ||
                       (row == '0) || (row == RW'(ACTIVE_ROWS - 1));

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        case (pat_q)
            PAT_BLACK: begin
            end
            PAT_RED:   red_d   = FULL;
            PAT_GREEN: green_d = FULL;
            PAT_BLUE:  blue_d  = FULL;
            PAT_CHECKER: begin
                if (col[CHECK_LOG2] ^ row[CHECK_LOG2]) begin
                    red_d   = FULL;
                    green_d = FULL;
                    blue_d  = FULL;
                end
            end
            PAT_BARS: begin
                red_d   = {VIDEO_WIDTH{bar_rgb[2]}};
                green_d = {VIDEO_WIDTH{bar_rgb[1]}};
                blue_d  = {VIDEO_WIDTH{bar_rgb[0]}};
            end
            PAT_BORDER: begin
                if (on_border) begin
                    red_d   = FULL;
                    green_d = FULL;
                    blue_d  = FULL;
                end
            end
            PAT_RAMP: begin
                red_d   = ramp_full[VIDEO_WIDTH-1:0];
                green_d = ramp_full[VIDEO_WIDTH-1:0];
                blue_d  = ramp_full[VIDEO_WIDTH-1:0];
            end
            default: begin
            end
        endcase
        if (!de || i_blank) begin
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hsync       <= ~HSYNC_POL;
            o_vsync       <= ~VSYNC_POL;
            o_de          <= 1'b0;
            o_frame_start <= 1'b0;
            o_line_start  <= 1'b0;
            o_col         <= '0;
            o_row         <= '0;
            o_red         <= '0;
            o_green       <= '0;
            o_blue        <= '0;
        end else begin
            o_hsync       <= hsync_on ? HSYNC_POL : ~HSYNC_POL;
            o_vsync       <= vsync_on ? VSYNC_POL : ~VSYNC_POL;
            o_de          <= de;
            o_frame_start <= frame_start;
            o_line_start  <= line_start;
            o_col         <= col;
            o_row         <= row;
            o_red         <= red_d;
            o_green       <= green_d;
            o_blue        <= blue_d;
        end
    end

endmodule

// File: doc/vga_timing_pattern_gen.md
Name: vga_timing_pattern_gen

Overview:
- Parametrised successor to the fixed 640x480 sync, pattern and porch chain.
- Generates VGA timing (sync, data-enable, frame/line markers) for any resolution and polarity, plus an 8-mode test pattern at VIDEO_WIDTH bits per colour.
- Pattern selection is synchronised and applied only at frame boundaries.
- Sits between the pixel-clock PLL and the VGA pins.

Parameters:
- VIDEO_WIDTH, 3, bits per colour channel (>=1).
- ACTIVE_COLS, 640, visible pixels per line (multiple of 8).
- H_FRONT, 16, horizontal front porch, pixels.
- H_SYNC, 96, hsync width, pixels.
- H_BACK, 48, horizontal back porch, pixels.
- ACTIVE_ROWS, 480, visible lines.
- V_FRONT, 10, vertical front porch, lines.
- V_SYNC, 2, vsync width, lines.
- V_BACK, 33, vertical back porch, lines.
- HSYNC_POL, 0, asserted level of o_hsync.
- VSYNC_POL, 0, asserted level of o_vsync.
- CHECK_LOG2, 5, checkerboard square size = 2**CHECK_LOG2 pixels.

Derived localparams:
- TOTAL_COLS = ACTIVE_COLS + H_FRONT + H_SYNC + H_BACK.
- TOTAL_ROWS = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK.
- CW = $clog2(TOTAL_COLS); RW = $clog2(TOTAL_ROWS).
- BAR_W = ACTIVE_COLS/8.

Ports:
- i_clk, in, 1: pixel clock.
- i_rst_n, in, 1: asynchronous reset, active-low.
- i_pattern, in, 3: pattern select; asynchronous to i_clk is allowed.
- i_blank, in, 1: forces black video when high; sync timing is unaffected.
- o_hsync, out, 1: horizontal sync.
- o_vsync, out, 1: vertical sync.
- o_de, out, 1: high during active video.
- o_frame_start, out, 1: one-cycle pulse at pixel (0,0).
- o_line_start, out, 1: one-cycle pulse at column 0 of every line, including blanking lines.
- o_col, out, CW: column of the current output pixel.
- o_row, out, RW: row of the current output pixel.
- o_red, out, VIDEO_WIDTH: red channel.
- o_green, out, VIDEO_WIDTH: green channel.
- o_blue, out, VIDEO_WIDTH: blue channel.

Behaviour:

Counters:
- col counts 0..TOTAL_COLS-1 and wraps to 0.
- row increments when col wraps, counts 0..TOTAL_ROWS-1, and wraps to 0.

Output registration:
- Every output is registered. Outputs at cycle t+1 reflect counter state (c,r) at cycle t, so latency is 1 cycle.
- o_col = c, o_row = r.

Timing:
- o_de = (c < ACTIVE_COLS) && (r < ACTIVE_ROWS).
- hsync is asserted (= HSYNC_POL) for c in [ACTIVE_COLS+H_FRONT, ACTIVE_COLS+H_FRONT+H_SYNC-1]; otherwise it is ~HSYNC_POL.
- vsync is asserted for r in [ACTIVE_ROWS+V_FRONT, ACTIVE_ROWS+V_FRONT+V_SYNC-1], independent of c. Same polarity rule with VSYNC_POL.
- o_line_start = (c == 0).
- o_frame_start = (c == 0 && r == 0).

Pattern select:
- i_pattern passes through a 2-flop synchroniser into pat_sync.
- The active pattern register pat_q loads pat_sync only on the cycle where c == TOTAL_COLS-1 and r == TOTAL_ROWS-1.
- A change therefore never appears mid-frame. Latency is up to 1 frame plus 3 cycles.

Patterns (R,G,B; "1" means all-ones for the channel):
- 0: black.
- 1: solid red.
- 2: solid green.
- 3: solid blue.
- 4: checkerboard. White when c[CHECK_LOG2] ^ r[CHECK_LOG2] is 1, else black.
- 5: 8 colour bars, each BAR_W wide. Order: white, yellow, cyan, green, magenta, red, blue, black. Bar index comes from an incremental bar counter: it resets at c == 0 and advances when the in-bar counter reaches BAR_W-1. No divider is used.
- 6: 1-pixel white border (c == 0, c == ACTIVE_COLS-1, r == 0, r == ACTIVE_ROWS-1); interior is black.
- 7: horizontal grey ramp. All three channels = c >> ($clog2(ACTIVE_COLS) - VIDEO_WIDTH), truncated to VIDEO_WIDTH.

Video gating:
- When o_de would be 0, or i_blank is high (sampled in the same cycle as the counters), o_red, o_green and o_blue = 0.

Reset (async assert, sync-free deassert):
- Counters, bar counters, synchroniser and pat_q = 0.
- o_hsync = ~HSYNC_POL, o_vsync = ~VSYNC_POL.
- o_de, o_frame_start, o_line_start, o_col, o_row and all video outputs = 0.
- First cycle after release: counters are at (0,0). o_frame_start pulses on the second rising edge after release.
- Reset mid-frame restarts timing at (0,0) with pattern 0.

Elaboration:
- Illegal parameters must stop elaboration: any porch or sync width of 0, or ACTIVE_COLS % 8 != 0.

Decomposition:
- Shared package vga_pkg holds:
  - pattern code localparams (PAT_BLACK .. PAT_RAMP);
  - the colour-bar RGB bit table;
  - a 640x480@60 default timing constant set.
- One sub-module, vga_timing_counter, produces c, r, the sync/de/start strobes and the frame-end strobe.
- The top-level handles the pattern select logic and colour generation.

Test Plan:
- Bench configuration: ACTIVE 16x8, H porches 2/3/2 (total 23), V porches 1/2/1 (total 12), VIDEO_WIDTH 3, CHECK_LOG2 2.
1. Default timing, pattern 0 -> o_hsync low for exactly 3 cycles starting at o_col == 18; o_vsync low for exactly 2 lines starting at o_row == 9; o_de count per frame = 128; o_frame_start period = 276 cycles.
2. HSYNC_POL = 1, VSYNC_POL = 1 -> same windows with inverted levels; idle level after reset is 0.
3. Pattern 5 -> o_col 0,1 give RGB 7/7/7; o_col 2,3 give 7/7/0; o_col 14,15 give 0/0/0; blanking region gives 0.
4. Change i_pattern 1 -> 4 at o_row == 3 -> rest of frame stays solid red (7/0/0); next frame shows checkerboard, with pixel (4,0) = white and (0,0) = black.
5. Pattern 7 -> o_col 0 gives 0, o_col 2 gives 1, o_col 15 gives 7; i_blank pulsed high for 1 cycle -> exactly one active pixel is black and sync is unaffected.
6. Assert i_rst_n low mid-line, asynchronously between edges -> outputs immediately take reset values; after release, o_frame_start pulses on the 2nd edge, o_col/o_row restart at 0, and the pattern is 0.
